// File: rtl/tdm_demux_4x1.sv
// tdm_demux_4x1: receive end of a 4-slot TDM link, reassembles slots into registered parallel frames
module tdm_demux_4x1 #(
  parameter int W   = 1,
  parameter int FCW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           sync,
  input  logic [W-1:0]   din,
  output logic [4*W-1:0] q,
  output logic           valid,
  output logic [1:0]     slot,
  output logic           locked,
  output logic           resync_err,
  output logic [FCW-1:0] frame_cnt
);
  logic [1:0]          slot_q, slot_d;
  logic [2:0][W-1:0]   sh_q, sh_d;
  logic [4*W-1:0]      q_q, q_d;
  logic                valid_q, valid_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic [FCW-1:0]      cnt_q, cnt_d;
  always_comb begin
    slot_d   = slot_q;
    sh_d     = sh_q;
    q_d      = q_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    locked_d = locked_q;
    cnt_d    = cnt_q;
    if (en && sync) begin
      sh_d[0]  = din;
      slot_d   = 2'd1;
      locked_d = 1'b1;
      err_d    = locked_q && slot_q != 2'd0;
    end else if (en && locked_q) begin
      if (slot_q == 2'd3) begin
        q_d     = {din, sh_q[2], sh_q[1], sh_q[0]};
        valid_d = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        slot_d  = 2'd0;
      end else begin
        for (int i = 0; i < 3; i++)
          if (slot_q == 2'(i)) sh_d[i] = din;
        slot_d = slot_q + 2'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q   <= '0;
      sh_q     <= '0;
      q_q      <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      slot_q   <= slot_d;
      sh_q     <= sh_d;
      q_q      <= q_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end
  assign q          = q_q;
  assign valid      = valid_q;
  assign slot       = slot_q;
  assign locked     = locked_q;
  assign resync_err = err_q;
  assign frame_cnt  = cnt_q;
endmodule

// File: tb/tb_tdm_demux_4x1.sv
// tb_tdm_demux_4x1: directed and randomized checks of tdm_demux_4x1 against a frame-level queue model
module tb_tdm_demux_4x1;
  localparam int W   = 1;
  localparam int FCW = 2;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           sync = 1'b0;
  logic [W-1:0]   din = '0;
  logic [4*W-1:0] q;
  logic           valid;
  logic [1:0]     slot;
  logic           locked;
  logic           resync_err;
  logic [FCW-1:0] frame_cnt;
  int n_chk = 0;
  int n_err = 0;
  int n_valid = 0;
  int n_rerr = 0;
  logic [W-1:0]   m_buf[$];
  logic [4*W-1:0] m_q = '0;
  bit             m_valid = 0;
  bit             m_err = 0;
  bit             m_locked = 0;
  int             m_cnt = 0;
  tdm_demux_4x1 #(.W(W), .FCW(FCW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .din(din),
    .q(q), .valid(valid), .slot(slot), .locked(locked),
    .resync_err(resync_err), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_step(input bit r, input bit e, input bit s, input logic [W-1:0] d);
    m_valid = 0;
    m_err = 0;
    if (!r) begin
      m_buf.delete();
      m_q = '0;
      m_locked = 0;
      m_cnt = 0;
    end else if (e) begin
      if (s) begin
        m_err = m_locked && m_buf.size() != 0;
        m_buf.delete();
        m_buf.push_back(d);
        m_locked = 1;
      end else if (m_locked) begin
        m_buf.push_back(d);
        if (m_buf.size() == 4) begin
          m_q = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
          m_valid = 1;
          m_cnt = (m_cnt + 1) % (1 << FCW);
          m_buf.delete();
        end
      end
    end
  endtask
  task automatic cyc(input bit r, input bit e, input bit s, input logic [W-1:0] d);
    rst_n = r;
    en = e;
    sync = s;
    din = d;
    @(posedge clk);
    model_step(r, e, s, d);
    #1;
    if (valid) n_valid++;
    if (resync_err) n_rerr++;
    chk("q", q, m_q);
    chk("valid", valid, m_valid);
    chk("slot", slot, m_buf.size());
    chk("locked", locked, m_locked);
    chk("resync_err", resync_err, m_err);
    chk("frame_cnt", frame_cnt, m_cnt);
  endtask
  task automatic frame(input bit s0, input logic [3:0] bits);
    cyc(1, 1, s0, bits[0]);
    cyc(1, 1, 0, bits[1]);
    cyc(1, 1, 0, bits[2]);
    cyc(1, 1, 0, bits[3]);
  endtask
  initial begin
    logic [3:0] gap_bits;
    int v0;
    int last_v;
    int gap;
    repeat (2) begin
      cyc(0, 1, 1, 1);
      chk("rst_q", q, 0);
      chk("rst_slot", slot, 0);
      chk("rst_locked", locked, 0);
    end
    frame(1, 4'b1100);
    chk("basic_q", q, 4'b1100);
    chk("basic_valid", valid, 1);
    chk("basic_cnt", frame_cnt, 1);
    chk("basic_slot", slot, 0);
    cyc(0, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 1);
    chk("prelock_slot", slot, 0);
    chk("prelock_locked", locked, 0);
    v0 = n_valid;
    frame(1, 4'b0101);
    chk("cont_q1", q, 4'b0101);
    chk("cont_v1", valid, 1);
    cyc(1, 1, 0, 0);
    chk("cont_nov", valid, 0);
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 1);
    chk("cont_q2", q, 4'b1110);
    chk("cont_v2", valid, 1);
    chk("cont_cnt", frame_cnt, 2);
    chk("cont_npulse", n_valid - v0, 2);
    v0 = n_valid;
    gap_bits = 4'b1100;
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, k == 0, gap_bits[k]);
      if (k < 3)
        for (int g = 0; g < 3; g++) begin
          cyc(1, 0, g[0], ~gap_bits[k]);
          chk("gap_slot", slot, k + 1);
        end
    end
    chk("gap_q", q, 4'b1100);
    chk("gap_npulse", n_valid - v0, 1);
    v0 = n_valid;
    gap = n_rerr;
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    frame(1, 4'b1011);
    chk("resync_q", q, 4'b1011);
    chk("resync_npulse", n_valid - v0, 1);
    chk("resync_nerr", n_rerr - gap, 1);
    cyc(1, 1, 1, 1);
    cyc(1, 1, 0, 1);
    chk("mid_slot2", slot, 2);
    cyc(0, 1, 0, 1);
    chk("midrst_slot", slot, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_q", q, 0);
    for (int f = 0; f < 5; f++) begin
      frame(f == 0, 4'($urandom));
      chk("wrap_cnt", frame_cnt, (f + 1) % 4);
    end
    last_v = -1;
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7,
          $urandom_range(0, 19) == 0, W'($urandom));
      if (valid) begin
        if (last_v >= 0 && i - last_v < 4) chk("valid_spacing", i - last_v, 4);
        last_v = i;
      end
      if (!rst_n) last_v = -1;
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
